// File: rtl/mem_responder.sv
// Memory-side responder for a single-cycle core. Loads a program from a byte
// stream (LOAD), then serves instruction fetches, data reads and stores (RUN).
module mem_responder #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [31:0] insn_addr,
    output logic [31:0] insn,
    input  logic        data_w,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        running,
    output logic        load_ovf,
    output logic        oob
);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic              load_ovf_q, load_ovf_d;
    logic              oob_q, oob_d;

    logic [31:0]       mem [DEPTH];

    logic              load_xfer;
    logic              full;
    logic              commit;
    logic              insn_in_range;
    logic              data_in_range;
    logic [31:0]       asm_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    assign load_xfer     = load_valid && (state_q == StLoad);
    assign full          = (wr_ptr_q == (ADDR_W + 1)'(DEPTH));
    assign commit        = load_xfer && ((byte_idx_q == 2'd3) || load_last);
    // Any address bit at or above ADDR_W makes the access out of range.
    assign insn_in_range = ((insn_addr >> ADDR_W) == 32'd0);
    assign data_in_range = ((data_addr >> ADDR_W) == 32'd0);
    // Lanes above byte_idx are still zero because asm_q is cleared on every commit.
    assign asm_word      = asm_q | ({24'd0, load_byte} << {byte_idx_q, 3'b000});

    // Single write port: loader commits in LOAD, core stores in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = data_addr[ADDR_W-1:0];
        mem_wdata = data_out;
        if (state_q == StLoad) begin
            mem_we    = commit && !full;
            mem_waddr = wr_ptr_q[ADDR_W-1:0];
            mem_wdata = asm_word;
        end else begin
            mem_we    = data_w && data_in_range;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Array storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic for the loader FSM and sticky error flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        load_ovf_d = load_ovf_q;
        oob_d      = oob_q;
        unique case (state_q)
            StLoad: begin
                if (load_xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    asm_d      = asm_word;
                    // Bytes keep being accepted when full; they are just dropped.
                    if (full) begin
                        load_ovf_d = 1'b1;
                    end
                    if (commit) begin
                        asm_d = 32'd0;
                        if (!full) begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                    if (load_last) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // data_addr counts as presented every RUN cycle.
                if (!insn_in_range || !data_in_range) begin
                    oob_d = 1'b1;
                end
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            wr_ptr_q   <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            load_ovf_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            load_ovf_q <= load_ovf_d;
            oob_q      <= oob_d;
        end
    end

    // Combinational read ports; zero (a no-op for the core) outside RUN.
    always_comb begin
        insn    = 32'd0;
        data_in = 32'd0;
        if (state_q == StRun) begin
            if (insn_in_range) begin
                insn = mem[insn_addr[ADDR_W-1:0]];
            end
            if (data_in_range) begin
                data_in = mem[data_addr[ADDR_W-1:0]];
            end
        end
    end

    assign load_ready = (state_q == StLoad);
    assign running    = (state_q == StRun);
    assign load_ovf   = load_ovf_q;
    assign oob        = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_mem_responder;

    localparam int SInsn = 0, SDataIn = 1, SRunning = 2, SReady = 3, SOvf = 4, SOob = 5;
    localparam int SInsn4 = 6, SReady4 = 7, SOvf4 = 8, SRunning4 = 9, SDataIn4 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (DEPTH=4096)
    logic        rst = 1'b1, load_valid = 1'b0, load_last = 1'b0, data_w = 1'b0;
    logic [7:0]  load_byte = 8'd0;
    logic [31:0] insn_addr = 32'd0, data_addr = 32'd0, data_out = 32'd0;
    logic        load_ready, running, load_ovf, oob;
    logic [31:0] insn, data_in;

    // Small instance (DEPTH=4) for overflow behaviour
    logic        rst4 = 1'b1, lv4 = 1'b0, ll4 = 1'b0;
    logic [7:0]  lb4 = 8'd0;
    logic [31:0] ia4 = 32'd0, da4 = 32'd0;
    logic        load_ready4, running4, load_ovf4, oob4;
    logic [31:0] insn4, data_in4;

    mem_responder dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte),
        .load_last(load_last), .load_ready(load_ready), .insn_addr(insn_addr),
        .insn(insn), .data_w(data_w), .data_addr(data_addr), .data_out(data_out),
        .data_in(data_in), .running(running), .load_ovf(load_ovf), .oob(oob)
    );

    mem_responder #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst4), .load_valid(lv4), .load_byte(lb4),
        .load_last(ll4), .load_ready(load_ready4), .insn_addr(ia4),
        .insn(insn4), .data_w(1'b0), .data_addr(da4), .data_out(32'd0),
        .data_in(data_in4), .running(running4), .load_ovf(load_ovf4), .oob(oob4)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SInsn:     return insn;
            SDataIn:   return data_in;
            SRunning:  return 32'(running);
            SReady:    return 32'(load_ready);
            SOvf:      return 32'(load_ovf);
            SOob:      return 32'(oob);
            SInsn4:    return insn4;
            SReady4:   return 32'(load_ready4);
            SOvf4:     return 32'(load_ovf4);
            SRunning4: return 32'(running4);
            SDataIn4:  return data_in4;
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is checked at that cycle's negedge.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = observe(e.sel);
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b, input logic last);
        lv4 = 1'b1;
        lb4 = b;
        ll4 = last;
        cyc();
        lv4 = 1'b0;
        ll4 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    logic [7:0]  prog1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] words4 [5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                                32'h100F0E0D, 32'h00000000};

    initial begin
        // Reset state
        cyc();
        do_reset();
        expect_v("rst_ready", SReady, 32'd1);
        expect_v("rst_running", SRunning, 32'd0);
        expect_v("rst_insn", SInsn, 32'd0);
        expect_v("rst_data_in", SDataIn, 32'd0);
        expect_v("rst_ovf", SOvf, 32'd0);
        expect_v("rst_oob", SOob, 32'd0);

        // Eight-byte program, two words
        for (int i = 0; i < 8; i++) begin
            send(prog1[i], i == 7);
            if (i < 7) begin
                expect_v("load1_insn_zero", SInsn, 32'd0);
                expect_v("load1_ready", SReady, 32'd1);
                expect_v("load1_not_running", SRunning, 32'd0);
            end
        end
        expect_v("run1_running", SRunning, 32'd1);
        expect_v("run1_ready_low", SReady, 32'd0);
        expect_v("run1_insn0", SInsn, 32'h12345678);
        expect_v("run1_data0", SDataIn, 32'h12345678);
        cyc();
        insn_addr = 32'd1;
        data_addr = 32'd1;
        expect_v("run1_insn1", SInsn, 32'hDEADBEEF);
        expect_v("run1_data1", SDataIn, 32'hDEADBEEF);
        cyc();

        // Five bytes: last on lane 0 of the second word
        do_reset();
        expect_v("rst2_running", SRunning, 32'd0);
        expect_v("rst2_insn", SInsn, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), i == 5);
            if (i < 5) begin
                expect_v("load2_insn_zero", SInsn, 32'd0);
                expect_v("load2_data_zero", SDataIn, 32'd0);
            end
        end
        data_addr = 32'd0;
        expect_v("run2_running", SRunning, 32'd1);
        expect_v("run2_mem1_partial", SInsn, 32'h00000005);
        expect_v("run2_mem0", SDataIn, 32'h04030201);
        cyc();

        // Store, then read-during-write on the same address
        data_w    = 1'b1;
        data_addr = 32'd7;
        data_out  = 32'h11112222;
        cyc();
        data_out  = 32'hCAFEF00D;
        insn_addr = 32'd7;
        expect_v("rdw_insn_old", SInsn, 32'h11112222);
        expect_v("rdw_data_old", SDataIn, 32'h11112222);
        cyc();
        data_w = 1'b0;
        expect_v("rdw_insn_new", SInsn, 32'hCAFEF00D);
        expect_v("rdw_data_new", SDataIn, 32'hCAFEF00D);
        expect_v("rdw_oob_clear", SOob, 32'd0);
        cyc();
        data_w    = 1'b1;
        data_addr = 32'd3;
        data_out  = 32'h33333333;
        cyc();
        data_w    = 1'b0;
        insn_addr = 32'd3;
        expect_v("store3_insn", SInsn, 32'h33333333);
        cyc();

        // Out-of-range store and fetch
        data_addr = 32'h00001000;
        data_w    = 1'b1;
        data_out  = 32'hBAADBAAD;
        insn_addr = 32'd0;
        expect_v("oob_data_in_zero", SDataIn, 32'd0);
        expect_v("oob_not_yet", SOob, 32'd0);
        cyc();
        data_w    = 1'b0;
        data_addr = 32'd0;
        insn_addr = 32'h00010003;
        expect_v("oob_set", SOob, 32'd1);
        expect_v("oob_mem0_untouched", SDataIn, 32'h04030201);
        expect_v("oob_insn_zero", SInsn, 32'd0);
        cyc();
        insn_addr = 32'd3;
        expect_v("oob_sticky", SOob, 32'd1);
        expect_v("oob_insn3", SInsn, 32'h33333333);
        cyc();

        // Loader ignored in RUN
        load_valid = 1'b1;
        load_byte  = 8'hAA;
        load_last  = 1'b1;
        insn_addr  = 32'd0;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
        expect_v("run_ignore_load", SRunning, 32'd1);
        expect_v("run_ignore_mem0", SInsn, 32'h04030201);
        cyc();

        // Reset mid-word discards the partial word
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_v("midrst_ready", SReady, 32'd1);
        expect_v("midrst_running", SRunning, 32'd0);
        expect_v("midrst_oob", SOob, 32'd0);
        expect_v("midrst_ovf", SOvf, 32'd0);
        expect_v("midrst_insn", SInsn, 32'd0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        data_addr = 32'd1;
        expect_v("midrst_running_after", SRunning, 32'd1);
        expect_v("midrst_mem0", SInsn, 32'h44332211);
        expect_v("midrst_mem1_persist", SDataIn, 32'h00000005);
        cyc();

        // Overflow on a four-word array
        rst4 = 1'b0;
        expect_v("d4_ready", SReady4, 32'd1);
        expect_v("d4_ovf_rst", SOvf4, 32'd0);
        for (int n = 1; n <= 20; n++) begin
            send4(8'(n), n == 20);
            if (n < 20) begin
                expect_v("d4_ready_hold", SReady4, 32'd1);
            end
            expect_v("d4_ovf", SOvf4, (n >= 17) ? 32'd1 : 32'd0);
        end
        expect_v("d4_running", SRunning4, 32'd1);
        expect_v("d4_ready_low", SReady4, 32'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            ia4 = 32'(k);
            da4 = 32'(k);
            expect_v("d4_word", SInsn4, words4[k]);
            expect_v("d4_data", SDataIn4, words4[k]);
            cyc();
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-cycle core's instruction-fetch and data ports, with a byte-stream program loader. After reset it sits in LOAD and assembles incoming bytes into 32-bit words in its word array. Once the final byte is marked it switches to RUN and serves `insn` and `data_in` to the core, committing core stores on the clock edge. It occupies the memory/testbench side of the core's `insn_addr`/`insn` and `data_*` ports.

## Interface
- `DEPTH`, 4096: number of 32-bit words in the array.
- `ADDR_W`, 12: index width; `DEPTH` must equal 2**`ADDR_W`.

Ports:
- `clk` in 1: sole clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: loader byte valid.
- `load_byte` in 8: loader byte, little-endian within each word (first byte goes to [7:0]).
- `load_last` in 1: qualifies the current byte as the final program byte.
- `load_ready` out 1: loader may transfer; high only in LOAD.
- `insn_addr` in 32: core fetch word address.
- `insn` out 32: fetched word.
- `data_w` in 1: core store enable.
- `data_addr` in 32: core data word address.
- `data_out` in 32: core store data.
- `data_in` out 32: data read word to core.
- `running` out 1: high in RUN.
- `load_ovf` out 1: sticky; a byte arrived after the array was full.
- `oob` out 1: sticky; a RUN-state access had an address ≥ `DEPTH`.

## Operation
- FSM states:
  - LOAD: reset state.
  - RUN: entered after the transfer with `load_last`=1. There is no path back to LOAD except `rst`.
- Reset: forces the following. Array contents are not cleared.
  - state=LOAD
  - `wr_ptr`=0 (`ADDR_W`+1 bits)
  - `byte_idx`=0 (2 bits)
  - assembly register=0
  - `load_ovf`=0, `oob`=0
- LOAD transfer (`load_valid` & `load_ready` at posedge):
  - The byte is placed in lane `byte_idx`, and `byte_idx` increments mod 4.
  - Word commit happens when `byte_idx`==3 or `load_last`=1. The assembled word goes to `mem[wr_ptr]`; unfilled upper lanes are written as 0. Then `wr_ptr`++ and the assembly register is cleared.
  - If `wr_ptr`==`DEPTH` at commit time, no write occurs, `wr_ptr` holds and `load_ovf` is set. Bytes are still accepted and no stall is applied.
  - If `load_last`=1, the state becomes RUN at this edge.
- LOAD outputs:
  - `insn`=0. This encoding is a no-op for the core: no register write, no store, no branch.
  - `data_in`=0.
  - `data_w` is ignored.
- RUN reads are combinational:
  - `insn` = `mem[insn_addr[ADDR_W-1:0]]` if `insn_addr` < `DEPTH`, else 0.
  - `data_in` = `mem[data_addr[ADDR_W-1:0]]` if `data_addr` < `DEPTH`, else 0.
  - Addresses are unsigned; any bit set above `ADDR_W` counts as out of range.
- RUN stores: when `data_w`=1 and `data_addr` < `DEPTH`, `mem[data_addr]` ← `data_out` at posedge.
- `oob` is set at posedge in RUN whenever either of these holds:
  - `insn_addr` ≥ `DEPTH`;
  - `data_w`=1 or a data access is presented with `data_addr` ≥ `DEPTH`. Treat `data_addr` as always presented in RUN.
- `load_valid` in RUN is ignored.

## Timing
- `load_ready` = (state==LOAD), decoded directly from the state register.
- `running` = (state==RUN), also from the state register. Both are valid the cycle after `rst` deasserts: `load_ready`=1, `running`=0.
- Load latency: a committed word is visible on `insn`/`data_in` in the first RUN cycle if its address is presented.
- `running` rises the cycle after the `load_last` transfer.
- Read-during-write, same address, same cycle: `data_in` and `insn` show the old word. The new word is visible from the next cycle.
- `rst` asserted mid-load discards the partial word. Already-committed words persist, and `wr_ptr` returns to 0.
- `rst` in RUN returns to LOAD at that edge. `insn`=0 from the next cycle.
- `load_last` with `byte_idx`==0 commits a word holding only lane 0.

## Test plan
- Reset then load bytes 78,56,34,12,EF,BE,AD,DE with `load_last` on the 8th byte, then drive `insn_addr`=0,1 → `insn`=0x12345678, 0xDEADBEEF; `running`=1 from the cycle after byte 8.
- Load 5 bytes 01..05 with last on byte 5 → `mem[1]`=0x00000005, `wr_ptr`=2; `insn` was 0 throughout LOAD.
- RUN: `data_w`=1, `data_addr`=7, `data_out`=0xCAFEF00D with `insn_addr`=7 the same cycle → `insn`=old value that cycle, 0xCAFEF00D the next; `data_in`@7 = 0xCAFEF00D after the edge.
- RUN: `data_addr`=0x1000, `data_w`=1 → no array change, `oob`=1 and it stays set; `insn_addr`=0x00010003 → `insn`=0.
- `DEPTH`=4: stream 20 bytes → first 16 stored, `load_ovf`=1 after byte 17, `load_ready` stays 1 until last.
- Assert `rst` after 2 bytes of a word → `byte_idx`=0, `load_ready`=1, `running`=0, `load_ovf`=`oob`=0; the next 4 bytes commit to `mem[0]`.
